// File: rtl/ro_puf_response_reader_if.sv
// Host-side bundle between the RO-PUF response reader and its environment.
// Carries the run request, the PUF array select/enable/clear and counter values,
// and the response word with its valid/ready handshake.
interface ro_puf_response_reader_if #(
  parameter int NUM_BITS = 16
);
  logic                start;
  logic [3:0]          offset;
  logic [11:0]         count1;
  logic [11:0]         count2;
  logic                response_ready;
  logic [3:0]          ro_select1;
  logic [3:0]          ro_select2;
  logic                ro_enable;
  logic                ro_reset;
  logic [NUM_BITS-1:0] response;
  logic                response_valid;
  logic                busy;
  logic [7:0]          tie_count;

  // Reader side: drives the array controls and the response.
  modport master (
    input  start, offset, count1, count2, response_ready,
    output ro_select1, ro_select2, ro_enable, ro_reset,
    output response, response_valid, busy, tie_count
  );

  // Environment side: host, PUF array and response consumer.
  modport slave (
    output start, offset, count1, count2, response_ready,
    input  ro_select1, ro_select2, ro_enable, ro_reset,
    input  response, response_valid, busy, tie_count
  );
endinterface

// File: rtl/ro_puf_response_reader.sv
// RO-PUF challenge sequencer: per bit clears a pair, measures WINDOW cycles, settles, compares counts.
// Latency: NUM_BITS*(WINDOW+SETTLE+3) cycles from start to response_valid; all outputs registered.
// Backpressure: holds response/valid in DONE until response_ready; start ignored while busy.
module ro_puf_response_reader #(
  parameter int NUM_BITS = 16,
  parameter int WINDOW   = 4095,
  parameter int SETTLE   = 3
) (
  input logic                     clock,
  input logic                     reset,
  ro_puf_response_reader_if.master bus
);

  localparam int IDX_W = 7;
  localparam int CNT_W = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MEASURE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [3:0]          r_off;

  logic [3:0]          r_sel1;
  logic [3:0]          r_sel2;
  logic                r_en;
  logic                r_rst;
  logic [NUM_BITS-1:0] r_resp;
  logic                r_vld;
  logic                r_busy;
  logic [7:0]          r_tie;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [IDX_W-1:0]    w_idx_inc;
  logic [3:0]          w_off_nxt;
  logic                w_launch;
  logic                w_capture;

  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_capture = (r_state == S_CAPTURE);

  // Next-state, phase counter, bit index and latched offset decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_off_nxt   = r_off;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.start) begin
          w_launch    = 1'b1;
          // A zero offset would compare an oscillator with itself.
          w_off_nxt   = (bus.offset == 4'd0) ? 4'd1 : bus.offset;
          w_idx_nxt   = '0;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (r_cnt == CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (r_cnt == CNT_W'(WINDOW - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_cnt_nxt   = '0;
        w_idx_nxt   = w_idx_inc;
        w_state_nxt = (w_idx_inc == IDX_W'(NUM_BITS)) ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        w_cnt_nxt = '0;
        if (bus.response_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, phase counter, bit index and effective offset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_off   <= 4'd1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_off   <= w_off_nxt;
    end
  end

  // Array controls and status flags registered from the next state so they align with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_vld  <= 1'b0;
      r_en   <= 1'b0;
      r_rst  <= 1'b1;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_vld  <= (w_state_nxt == S_DONE);
      r_en   <= (w_state_nxt == S_MEASURE);
      r_rst  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_CLEAR) ||
                (w_state_nxt == S_DONE);
    end
  end

  // Pair selects load on entry to CLEAR and hold through CAPTURE; index wraps mod 16.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sel1 <= '0;
      r_sel2 <= '0;
    end else if ((w_state_nxt == S_CLEAR) && (r_state != S_CLEAR)) begin
      r_sel1 <= w_idx_nxt[3:0];
      r_sel2 <= w_idx_nxt[3:0] + w_off_nxt;
    end
  end

  // Response bit capture and saturating tie counter; both cleared when a run launches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_resp <= '0;
      r_tie  <= '0;
    end else if (w_launch) begin
      r_resp <= '0;
      r_tie  <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < NUM_BITS; i++) begin
        if (r_idx == IDX_W'(i)) begin
          r_resp[i] <= (bus.count1 > bus.count2);
        end
      end
      if ((bus.count1 == bus.count2) && (r_tie != 8'hFF)) begin
        r_tie <= r_tie + 8'd1;
      end
    end
  end

  assign bus.ro_select1     = r_sel1;
  assign bus.ro_select2     = r_sel2;
  assign bus.ro_enable      = r_en;
  assign bus.ro_reset       = r_rst;
  assign bus.response       = r_resp;
  assign bus.response_valid = r_vld;
  assign bus.busy           = r_busy;
  assign bus.tie_count      = r_tie;

endmodule

// File: tb/tb_ro_puf_response_reader.sv
// Directed bench for ro_puf_response_reader with NUM_BITS=4, WINDOW=8, SETTLE=2.
// A vector table covers full runs; hand sequences cover interlock, backpressure and mid-run reset.
// The PUF array is modelled as per-oscillator count tables indexed by ro_select1.
module tb_ro_puf_response_reader;
  localparam int NB = 4;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int RUN_EDGES = NB * (W + S + 3);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ro_puf_response_reader_if #(.NUM_BITS(NB)) bus ();

  ro_puf_response_reader #(.NUM_BITS(NB), .WINDOW(W), .SETTLE(S)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [11:0] c1_tab [16];
  logic [11:0] c2_tab [16];

  // Array model: counts for the pair selected by ro_select1.
  always_comb begin
    bus.count1 = c1_tab[bus.ro_select1];
    bus.count2 = c2_tab[bus.ro_select1];
  end

  typedef struct {
    logic [3:0]  offset;
    logic [11:0] c1 [4];
    logic [11:0] c2 [4];
    logic [3:0]  exp_resp;
    logic [7:0]  exp_tie;
    logic [3:0]  exp_sel2 [4];
    bit          ready_early;
  } vec_t;

  vec_t vecs [4];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check($sformatf("%s_sel1", tag), 32'(bus.ro_select1), 32'd0);
    check($sformatf("%s_sel2", tag), 32'(bus.ro_select2), 32'd0);
    check($sformatf("%s_en", tag), 32'(bus.ro_enable), 32'd0);
    check($sformatf("%s_rst", tag), 32'(bus.ro_reset), 32'd1);
    check($sformatf("%s_resp", tag), 32'(bus.response), 32'd0);
    check($sformatf("%s_vld", tag), 32'(bus.response_valid), 32'd0);
    check($sformatf("%s_busy", tag), 32'(bus.busy), 32'd0);
    check($sformatf("%s_tie", tag), 32'(bus.tie_count), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  edge_n  = 0;
    int  en_cyc  = 0;
    int  overlap = 0;
    int  k       = 0;
    int  run_len = 0;
    bit  prev_en = 1'b0;
    bit  got     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c1_tab[i] = v.c1[i];
      c2_tab[i] = v.c2[i];
    end
    bus.offset         = v.offset;
    bus.response_ready = v.ready_early;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check($sformatf("%s_busy_rise", tag), 32'(bus.busy), 32'd1);
    while (!got && edge_n < 200) begin
      if (bus.ro_enable && bus.ro_reset) overlap++;
      if (bus.ro_enable) begin
        en_cyc++;
        run_len++;
      end else if (prev_en) begin
        check($sformatf("%s_en_run", tag), 32'(run_len), 32'(W));
        run_len = 0;
      end
      if (bus.ro_enable && !prev_en) begin
        if (k < 4) begin
          check($sformatf("%s_sel1_b%0d", tag, k), 32'(bus.ro_select1), 32'(k));
          check($sformatf("%s_sel2_b%0d", tag, k), 32'(bus.ro_select2), 32'(v.exp_sel2[k]));
        end
        k++;
      end
      prev_en = bus.ro_enable;
      if (bus.response_valid) begin
        got = 1'b1;
      end else begin
        @(negedge clock);
        edge_n++;
      end
    end
    check($sformatf("%s_valid_seen", tag), 32'(got), 32'd1);
    check($sformatf("%s_valid_edge", tag), 32'(edge_n), 32'(RUN_EDGES));
    check($sformatf("%s_en_cycles", tag), 32'(en_cyc), 32'(NB * W));
    check($sformatf("%s_en_rst_overlap", tag), 32'(overlap), 32'd0);
    check($sformatf("%s_pairs", tag), 32'(k), 32'(NB));
    check($sformatf("%s_resp", tag), 32'(bus.response), 32'(v.exp_resp));
    check($sformatf("%s_tie", tag), 32'(bus.tie_count), 32'(v.exp_tie));
    bus.response_ready = 1'b1;
    @(negedge clock);
    check($sformatf("%s_vld_drop", tag), 32'(bus.response_valid), 32'd0);
    check($sformatf("%s_busy_drop", tag), 32'(bus.busy), 32'd0);
    check($sformatf("%s_resp_held", tag), 32'(bus.response), 32'(v.exp_resp));
    bus.response_ready = 1'b0;
  endtask

  initial begin
    int e;
    vecs[0] = '{offset: 4'd3,
                c1: '{12'd200, 12'd200, 12'd200, 12'd200},
                c2: '{12'd100, 12'd100, 12'd100, 12'd100},
                exp_resp: 4'b1111, exp_tie: 8'd0,
                exp_sel2: '{4'd3, 4'd4, 4'd5, 4'd6}, ready_early: 1'b0};
    vecs[1] = '{offset: 4'd1,
                c1: '{12'd5, 12'd9, 12'd7, 12'd10},
                c2: '{12'd9, 12'd5, 12'd7, 12'd2},
                exp_resp: 4'b1010, exp_tie: 8'd1,
                exp_sel2: '{4'd1, 4'd2, 4'd3, 4'd4}, ready_early: 1'b0};
    vecs[2] = '{offset: 4'd0,
                c1: '{12'd1, 12'd1, 12'd1, 12'd1},
                c2: '{12'd1, 12'd1, 12'd1, 12'd1},
                exp_resp: 4'b0000, exp_tie: 8'd4,
                exp_sel2: '{4'd1, 4'd2, 4'd3, 4'd4}, ready_early: 1'b0};
    vecs[3] = '{offset: 4'd15,
                c1: '{12'd4095, 12'd0, 12'd4095, 12'd100},
                c2: '{12'd0, 12'd4095, 12'd4095, 12'd99},
                exp_resp: 4'b1001, exp_tie: 8'd1,
                exp_sel2: '{4'd15, 4'd0, 4'd1, 4'd2}, ready_early: 1'b1};

    for (int i = 0; i < 16; i++) begin
      c1_tab[i] = 12'd0;
      c2_tab[i] = 12'd0;
    end
    bus.start          = 1'b0;
    bus.offset         = 4'd0;
    bus.response_ready = 1'b0;
    reset              = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values("por");
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Start pulses during MEASURE and DONE are ignored; DONE holds under backpressure.
    for (int i = 0; i < 4; i++) begin
      c1_tab[i] = vecs[0].c1[i];
      c2_tab[i] = vecs[0].c2[i];
    end
    bus.offset = 4'd3;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    e = 0;
    while (!bus.ro_enable && e < 50) begin
      @(negedge clock);
      e++;
    end
    check("ilk_first_measure_edge", 32'(e), 32'd2);
    bus.start  = 1'b1;
    bus.offset = 4'd7;
    @(negedge clock);
    e++;
    bus.start  = 1'b0;
    bus.offset = 4'd3;
    while (!bus.response_valid && e < 200) begin
      @(negedge clock);
      e++;
    end
    check("ilk_valid_edge", 32'(e), 32'(RUN_EDGES));
    check("ilk_resp", 32'(bus.response), 32'hF);
    check("ilk_sel1_last", 32'(bus.ro_select1), 32'd3);
    check("ilk_sel2_last", 32'(bus.ro_select2), 32'd6);
    for (int c = 0; c < 10; c++) begin
      bus.start = (c == 4);
      @(negedge clock);
      check($sformatf("hold_vld_c%0d", c), 32'(bus.response_valid), 32'd1);
      check($sformatf("hold_resp_c%0d", c), 32'(bus.response), 32'hF);
    end
    bus.start = 1'b0;
    check("hold_busy", 32'(bus.busy), 32'd1);
    check("hold_tie", 32'(bus.tie_count), 32'd0);
    bus.response_ready = 1'b1;
    @(negedge clock);
    bus.response_ready = 1'b0;
    check("hs_vld_drop", 32'(bus.response_valid), 32'd0);
    check("hs_busy_drop", 32'(bus.busy), 32'd0);
    check("hs_resp_held", 32'(bus.response), 32'hF);
    @(negedge clock);
    check("hs_no_restart", 32'(bus.busy), 32'd0);

    // Asynchronous reset during MEASURE of bit 2, then a clean full run.
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    e = 0;
    while (!(bus.ro_enable && bus.ro_select1 == 4'd2) && e < 200) begin
      @(negedge clock);
      e++;
    end
    check("mid_bit2_found", 32'(e < 200), 32'd1);
    check("mid_partial_resp", 32'(bus.response), 32'h3);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("mid_rst");
    @(negedge clock);
    reset = 1'b0;
    run_vec(vecs[0], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
